// File: rtl/vga_sync_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_generator_if
// Description : Output bundle of the VGA timing generator. It carries the sync
//               and blank signals, the frame-buffer address, the active-pixel
//               coordinates and the start-of-frame marker.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_generator_if;
    logic        oHS;
    logic        oVS;
    logic        oBLANK_n;
    logic [18:0] oADDR;
    logic [9:0]  oX;
    logic [8:0]  oY;
    logic        oFRAME;

    // Timing generator side: drives every signal of the bundle.
    modport master (
        output oHS,
        output oVS,
        output oBLANK_n,
        output oADDR,
        output oX,
        output oY,
        output oFRAME
    );

    // Display-path side: ROM address, palette lookup and the board renderer.
    modport slave (
        input oHS,
        input oVS,
        input oBLANK_n,
        input oADDR,
        input oX,
        input oY,
        input oFRAME
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_generator
// Description : 640x480 @ 60 Hz VGA timing generator with a linear frame-buffer
//               address counter. Sync and blank are registered so that they
//               line up with the one-cycle ROM read that uses oADDR/oX/oY.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_generator #(
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 144,
    parameter int H_FRONT = 16,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 34,
    parameter int V_FRONT = 11
) (
    input  wire logic            iVGA_CLK,
    input  wire logic            iRST_n,
    vga_sync_generator_if.master vga
);

    // Counter-width copies of the timing constants.
    localparam logic [9:0] c_H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_H_SYNC    = 10'(H_SYNC);
    localparam logic [9:0] c_H_BACK    = 10'(H_BACK);
    localparam logic [9:0] c_H_ACT_END = 10'(H_TOTAL - H_FRONT);
    localparam logic [9:0] c_V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_V_SYNC    = 10'(V_SYNC);
    localparam logic [9:0] c_V_BACK    = 10'(V_BACK);
    localparam logic [9:0] c_V_ACT_END = 10'(V_TOTAL - V_FRONT);

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [18:0] r_addr;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_hs;
    logic        w_vs;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_blank_n;

    // Raw timing decode from the current counter position.
    assign w_h_wrap  = (r_h_cnt == c_H_LAST);
    assign w_v_wrap  = (r_v_cnt == c_V_LAST);
    assign w_hs      = (r_h_cnt >= c_H_SYNC);
    assign w_vs      = (r_v_cnt >= c_V_SYNC);
    assign w_h_act   = (r_h_cnt >= c_H_BACK) && (r_h_cnt < c_H_ACT_END);
    assign w_v_act   = (r_v_cnt >= c_V_BACK) && (r_v_cnt < c_V_ACT_END);
    assign w_blank_n = w_h_act && w_v_act;

    // Pixel and line counters; the line counter advances only on a line wrap.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                if (w_v_wrap) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + 10'd1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Frame-buffer address: cleared while both syncs are low, which only
    // happens in the first lines of a frame, and stepped once per active pixel.
    // The clear wins over the step so a mis-parameterised overlap still
    // restarts the frame cleanly.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_addr <= '0;
        end else if (!w_hs && !w_vs) begin
            r_addr <= '0;
        end else if (w_blank_n) begin
            r_addr <= r_addr + 19'd1;
        end
    end

    // One-clock delay of sync/blank to match the downstream ROM latency.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_blank_n <= 1'b0;
        end else begin
            r_hs      <= w_hs;
            r_vs      <= w_vs;
            r_blank_n <= w_blank_n;
        end
    end

    assign vga.oHS      = r_hs;
    assign vga.oVS      = r_vs;
    assign vga.oBLANK_n = r_blank_n;
    assign vga.oADDR    = r_addr;
    // Coordinates follow the counters directly and are forced to 0 in blanking.
    assign vga.oX       = w_blank_n ? 10'(r_h_cnt - c_H_BACK) : 10'd0;
    assign vga.oY       = w_blank_n ? 9'(r_v_cnt - c_V_BACK) : 9'd0;
    assign vga.oFRAME   = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_generator
// Description : Scoreboard bench. Two generators share clock and reset: one at
//               the 640x480 timing (first ~37 lines) and one with a shrunken
//               timing (40x20 total, 26x12 active) so whole frames fit in a
//               short run. Expected values are hand-computed per frame
//               position p = rising edges since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_generator;

    typedef struct {
        int          sel;    // 0 = full-size DUT, 1 = small DUT
        int          p;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [18:0] addr;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        fr;
        string       name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   pos;
    int   total;
    int   bad;
    bit   meas_on;
    vec_t q[$];

    int cnt_sbl, cnt_shs, cnt_svs, cnt_sfr, cnt_dbl, cnt_dhs, cnt_dfr;

    vga_sync_generator_if vif_d ();
    vga_sync_generator_if vif_s ();

    vga_sync_generator u_dut_full (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .vga      (vif_d)
    );

    vga_sync_generator #(
        .H_TOTAL (40),
        .H_SYNC  (6),
        .H_BACK  (10),
        .H_FRONT (4),
        .V_TOTAL (20),
        .V_SYNC  (2),
        .V_BACK  (5),
        .V_FRONT (3)
    ) u_dut_small (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .vga      (vif_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame position since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pos <= 0;
        else        pos <= pos + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (pos=%0d)", nm, act, exp, pos);
        end
    endtask

    task automatic cmp_vec(input vec_t v);
        if (v.sel == 0) begin
            chk({v.name, ".hs"},   int'(vif_d.oHS),      int'(v.hs));
            chk({v.name, ".vs"},   int'(vif_d.oVS),      int'(v.vs));
            chk({v.name, ".bl"},   int'(vif_d.oBLANK_n), int'(v.bl));
            chk({v.name, ".addr"}, int'(vif_d.oADDR),    int'(v.addr));
            chk({v.name, ".x"},    int'(vif_d.oX),       int'(v.x));
            chk({v.name, ".y"},    int'(vif_d.oY),       int'(v.y));
            chk({v.name, ".fr"},   int'(vif_d.oFRAME),   int'(v.fr));
        end else begin
            chk({v.name, ".hs"},   int'(vif_s.oHS),      int'(v.hs));
            chk({v.name, ".vs"},   int'(vif_s.oVS),      int'(v.vs));
            chk({v.name, ".bl"},   int'(vif_s.oBLANK_n), int'(v.bl));
            chk({v.name, ".addr"}, int'(vif_s.oADDR),    int'(v.addr));
            chk({v.name, ".x"},    int'(vif_s.oX),       int'(v.x));
            chk({v.name, ".y"},    int'(vif_s.oY),       int'(v.y));
            chk({v.name, ".fr"},   int'(vif_s.oFRAME),   int'(v.fr));
        end
    endtask

    function automatic vec_t mk(input int sel, input int p, input logic hs, input logic vs,
                                input logic bl, input int addr, input int x, input int y,
                                input logic fr, input string nm);
        vec_t v;
        v.sel  = sel;
        v.p    = p;
        v.hs   = hs;
        v.vs   = vs;
        v.bl   = bl;
        v.addr = 19'(addr);
        v.x    = 10'(x);
        v.y    = 9'(y);
        v.fr   = fr;
        v.name = nm;
        return v;
    endfunction

    task automatic push(input int sel, input int p, input logic hs, input logic vs,
                        input logic bl, input int addr, input int x, input int y,
                        input logic fr, input string nm);
        q.push_back(mk(sel, p, hs, vs, bl, addr, x, y, fr, nm));
    endtask

    // Monitor: compares queued expectations when their frame position comes up,
    // and accumulates per-frame signal statistics during the first phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (q.size() > 0 && q[0].p < pos) begin
                    chk({q[0].name, ".missed"}, pos, q[0].p);
                    void'(q.pop_front());
                end
                while (q.size() > 0 && q[0].p == pos) begin
                    cmp_vec(q[0]);
                    void'(q.pop_front());
                end
                if (meas_on) begin
                    if (pos >= 1 && pos <= 800) begin
                        if (vif_s.oBLANK_n) cnt_sbl++;
                        if (!vif_s.oHS)     cnt_shs++;
                        if (!vif_s.oVS)     cnt_svs++;
                        if (!vif_d.oHS)     cnt_dhs++;
                    end
                    if (pos >= 1 && pos <= 1600 && vif_s.oFRAME) cnt_sfr++;
                    if (pos >= 1 && pos <= 28800) begin
                        if (vif_d.oBLANK_n) cnt_dbl++;
                        if (vif_d.oFRAME)   cnt_dfr++;
                    end
                    if (pos == 800) begin
                        chk("s_blank_clocks_per_frame", cnt_sbl, 312);
                        chk("s_hs_low_per_frame", cnt_shs, 120);
                        chk("s_vs_low_per_frame", cnt_svs, 80);
                        chk("d_hs_low_line0", cnt_dhs, 96);
                    end
                    if (pos == 1600) chk("s_frame_pulses_2frames", cnt_sfr, 2);
                    if (pos == 28800) begin
                        chk("d_blank_lines0to35", cnt_dbl, 1280);
                        chk("d_no_frame_midframe", cnt_dfr, 0);
                    end
                end
            end
        end
    end

    // Stimulus: queue hand-computed expectations, then drive reset.
    initial begin
        total = 0; bad = 0; meas_on = 1'b0;
        cnt_sbl = 0; cnt_shs = 0; cnt_svs = 0; cnt_sfr = 0;
        cnt_dbl = 0; cnt_dhs = 0; cnt_dfr = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        cmp_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, "d_reset"));
        cmp_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, "s_reset"));

        //   sel p      hs vs bl addr  x    y   fr
        push(1, 1,     0, 0, 0, 0,    0,   0,  0, "s_p1");
        push(0, 1,     0, 0, 0, 0,    0,   0,  0, "d_p1");
        push(1, 7,     1, 0, 0, 0,    0,   0,  0, "s_hs_rise");
        push(1, 80,    1, 0, 0, 0,    0,   0,  0, "s_line2_start");
        push(1, 81,    0, 1, 0, 0,    0,   0,  0, "s_vs_rise");
        push(0, 96,    0, 0, 0, 0,    0,   0,  0, "d_hs_last_low");
        push(0, 97,    1, 0, 0, 0,    0,   0,  0, "d_hs_rise");
        push(1, 210,   1, 1, 0, 0,    0,   0,  0, "s_first_pixel");
        push(1, 211,   1, 1, 1, 1,    1,   0,  0, "s_second_pixel");
        push(1, 675,   1, 1, 1, 311,  25,  11, 0, "s_last_pixel");
        push(1, 676,   1, 1, 1, 312,  0,   0,  0, "s_after_last");
        push(1, 677,   1, 1, 0, 312,  0,   0,  0, "s_addr_hold");
        push(1, 799,   1, 1, 0, 312,  0,   0,  0, "s_frame_end");
        push(1, 800,   1, 1, 0, 312,  0,   0,  1, "s_frame_wrap");
        push(0, 800,   1, 0, 0, 0,    0,   0,  0, "d_line1_start");
        push(1, 801,   0, 0, 0, 0,    0,   0,  0, "s_addr_clear");
        push(0, 801,   0, 0, 0, 0,    0,   0,  0, "d_line1_hs_fall");
        push(1, 1010,  1, 1, 0, 0,    0,   0,  0, "s_f2_first_pixel");
        push(1, 1475,  1, 1, 1, 311,  25,  11, 0, "s_f2_last_pixel");
        push(1, 1600,  1, 1, 0, 312,  0,   0,  1, "s_f3_start");
        push(0, 1600,  1, 0, 0, 0,    0,   0,  0, "d_line2_start");
        push(0, 1601,  0, 1, 0, 0,    0,   0,  0, "d_vs_rise");
        push(0, 27344, 1, 1, 0, 0,    0,   0,  0, "d_pix_144_34");
        push(0, 27345, 1, 1, 1, 1,    1,   0,  0, "d_pix_145_34");
        push(0, 27983, 1, 1, 1, 639,  639, 0,  0, "d_pix_783_34");
        push(0, 27984, 1, 1, 1, 640,  0,   0,  0, "d_pix_784_34");
        push(0, 27985, 1, 1, 0, 640,  0,   0,  0, "d_pix_785_34");
        push(0, 28144, 1, 1, 0, 640,  0,   1,  0, "d_pix_144_35");
        push(0, 28145, 1, 1, 1, 641,  1,   1,  0, "d_pix_145_35");
        push(0, 28800, 1, 1, 0, 1280, 0,   0,  0, "d_line36_start");
        push(0, 28801, 0, 1, 0, 1280, 0,   0,  0, "d_line36_hs_fall");
        push(0, 29744, 1, 1, 0, 1920, 0,   3,  0, "d_pix_144_37");

        meas_on = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 40000 && pos < 30002; i++) @(negedge clk);
        chk("phase1_drained", q.size(), 0);
        q.delete();
        meas_on = 1'b0;

        // Mid-frame reset: the full DUT sits in active video at (400,37).
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, "d_midreset"));
        cmp_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, "s_midreset"));
        repeat (3) @(negedge clk);

        push(1, 1,   0, 0, 0, 0, 0, 0, 0, "s_r2_p1");
        push(0, 1,   0, 0, 0, 0, 0, 0, 0, "d_r2_p1");
        push(0, 2,   0, 0, 0, 0, 0, 0, 0, "d_r2_p2");
        push(1, 7,   1, 0, 0, 0, 0, 0, 0, "s_r2_hs_rise");
        push(0, 97,  1, 0, 0, 0, 0, 0, 0, "d_r2_hs_rise");
        push(1, 211, 1, 1, 1, 1, 1, 0, 0, "s_r2_second_pixel");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 1000 && pos < 300; i++) @(negedge clk);
        chk("phase2_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_generator.md
# vga_sync_generator

640x480 @ 60 Hz VGA timing generator with an integrated frame-buffer address counter. It produces the horizontal sync, vertical sync and blanking signals for the display path. It also produces a linear pixel address, active-pixel coordinates and a start-of-frame marker, which drive the image/palette ROMs and the game-board renderer. It sits between the pixel clock and the colour lookup logic in the VGA controller.

## Interface
- H_TOTAL, 800: pixel clocks per line.
- H_SYNC, 96: HS low width, in clocks, from line start.
- H_BACK, 144: first active column (sync plus back porch).
- H_FRONT, 16: front-porch width.
- V_TOTAL, 525: lines per frame.
- V_SYNC, 2: VS low width, in lines.
- V_BACK, 34: first active line.
- V_FRONT, 11: front-porch lines.

- iVGA_CLK  in  1  pixel clock, 25.175 MHz nominal. This is the only clock; all state updates on its rising edge.
- iRST_n  in  1  reset, asynchronous and active-low.
- oHS  out  1  horizontal sync, active low, registered.
- oVS  out  1  vertical sync, active low, registered.
- oBLANK_n  out  1  high during active video, registered.
- oADDR  out  19  linear pixel address, y*640+x.
- oX  out  10  active column 0..639. Valid only while the raw blank_n is high; 0 otherwise.
- oY  out  9  active row 0..479. Valid only while the raw blank_n is high; 0 otherwise.
- oFRAME  out  1  one-clock pulse on the first clock of a frame (h=0, v=0).

## Operation

Counters:
- h_cnt is 10 bits. It increments every clock and wraps from H_TOTAL-1 to 0.
- v_cnt is 10 bits. It increments only when h_cnt wraps, and wraps from V_TOTAL-1 to 0.

Raw combinational signals, derived from the current counter values:
- hs = (h_cnt >= H_SYNC).
- vs = (v_cnt >= V_SYNC).
- blank_n = (H_BACK <= h_cnt < H_TOTAL-H_FRONT) && (V_BACK <= v_cnt < V_TOTAL-V_FRONT).
- Active window is columns 144..783 and lines 34..513.

oX, oY and oFRAME:
- oX = h_cnt-H_BACK and oY = v_cnt-V_BACK while blank_n is high; both are 0 otherwise.
- oFRAME = (h_cnt==0 && v_cnt==0).

Address register, with priority in this order:
1. Reset: 0.
2. hs==0 && vs==0: 0.
3. blank_n==1: ADDR+1.
4. Otherwise: hold.

Consequences of the address rule:
- During any active pixel, oADDR equals y*640+x of that pixel.
- After the last pixel of a frame, oADDR holds at 307200 until it is cleared in lines 0..1 of the next frame.
- oADDR never exceeds 307200.

Registered outputs: oHS, oVS and oBLANK_n are the raw hs, vs and blank_n delayed by one clock. This compensates for the one-cycle ROM read latency downstream.

## Timing

Reset (iRST_n low) takes effect immediately, without waiting for a clock edge:
- h_cnt, v_cnt and ADDR are 0.
- oHS, oVS and oBLANK_n are 0.
- oADDR, oX and oY are 0.
- oFRAME is 1, because counters at 0,0 decode as frame start.

After reset release:
- The first rising edge gives h_cnt=1.
- Counting restarts from frame origin whenever reset is reasserted, including mid-frame. There is no partial-frame recovery.

Per-signal timing:
- Line period: 800 clocks. Raw hs is low for clocks 0..95 of each line.
- Frame period: 420000 clocks. Raw vs is low for lines 0..1, which is 1600 clocks.
- Active video: 640 clocks per line on lines 34..513, giving 307200 blank_n-high clocks per frame.
- Latency:
  - oHS, oVS and oBLANK_n lag the raw signals by exactly 1 clock.
  - oADDR, oX, oY and oFRAME have 0-clock latency relative to the counters.

Boundaries:
- At h_cnt=799 with v_cnt=524, the next clock gives h=0, v=0 and oFRAME=1.
- Address clear has priority over increment. They cannot coincide within legal parameters; the priority still holds if they do.

## Test plan
- Reset mid-frame:
  - Stimulus: hold iRST_n low at an arbitrary counter state.
  - Response: all counters and registered outputs are 0 without a clock edge; after release h_cnt counts from 1.
- Horizontal timing: measure oHS → period 800 clocks, low for 96, and oHS falls one clock after h_cnt=0.
- Vertical timing: measure oVS → period 420000 clocks, low for 1600.
- Blanking: count oBLANK_n high clocks per frame → 307200, arranged as 480 runs of 640. The first run starts one clock after h=144, v=34.
- Address sequence → oADDR is:
  - 0 at pixel (144,34);
  - 639 at (783,34);
  - 640 at (144,35);
  - 307199 at (783,513);
  - held at 307200 until h<96 on line 0 of the next frame, then 0.
- Coordinates and frame marker:
  - oX/oY read 0/0 at (144,34) and 639/479 at (783,513), and 0 in blanking.
  - oFRAME pulses once every 420000 clocks.
